hist_sweep_ctrl: RTL and testbench
==================================

# hist_sweep_ctrl

Sequencer and read-port arbiter for the 256-bin histogram block. When a frame's histogram completes, it sweeps every bin in order and streams `{cdf, bin_count}` on AXI4-Stream, accumulating the cumulative distribution for downstream equalization LUT generation. It also shares the histogram's single read port with a host single-word read interface. It sits between the histogram's read interface and the equalization/LUT stage.

## Interface
- `BIN_WIDTH`, 32, width of one histogram counter, of the CDF and of `total_count`
- `NUM_BINS`, 256, number of bins swept (addresses `0..NUM_BINS-1`)
- `ADDR_WIDTH`, 8, bin address width; equals log2(`NUM_BINS`)
- `clk`  in  1  clock
- `rst_n`  in  1  reset; asynchronous, active-low
- `hist_frame_done`  in  1  level from histogram; a rising edge triggers a sweep
- `hist_read_addr`  out  ADDR_WIDTH  histogram read address; read data returns 1 cycle later
- `hist_read_data`  in  BIN_WIDTH  histogram read data
- `host_req`  in  1  host read request; held high until `host_ack`
- `host_addr`  in  ADDR_WIDTH  host bin address; stable while `host_req` is high
- `host_ack`  out  1  1-cycle pulse; `host_data` is valid in the same cycle
- `host_data`  out  BIN_WIDTH  host read result; held until the next ack
- `m_axis_tvalid`  out  1  sweep output valid
- `m_axis_tready`  in  1  downstream ready
- `m_axis_tdata`  out  2*BIN_WIDTH  `{cdf[BIN_WIDTH-1:0], bin_count[BIN_WIDTH-1:0]}`
- `m_axis_tuser`  out  1  high on the bin-0 beat
- `m_axis_tlast`  out  1  high on the bin-(`NUM_BINS`-1) beat
- `sweep_busy`  out  1  high in any state other than IDLE
- `sweep_done`  out  1  1-cycle pulse when the sweep completes
- `total_count`  out  BIN_WIDTH  final CDF of the last completed sweep
- `cdf_sat`  out  1  sticky: the CDF saturated during the current or last sweep
- `overrun`  out  1  sticky: a trigger arrived while busy; cleared only by reset

## Operation
- Edge detection: `done_q` registers `hist_frame_done`. A trigger is `hist_frame_done & ~done_q`.
- Trigger accepted in IDLE:
  - clear `bin_idx`, `cdf` and `cdf_sat`;
  - go to READ.
- Trigger while busy: ignored; set `overrun`.
- FSM states: IDLE, READ, CAPTURE, OUT, DONE.
  - READ: the sweep owns the port; `hist_read_addr = bin_idx`. Next state is CAPTURE.
  - CAPTURE: `hist_read_data` holds the bin value.
    - Register `cdf_next = sat(cdf + data)`.
    - Load `m_axis_tdata = {cdf_next, data}`, `tuser = (bin_idx==0)`, `tlast = (bin_idx==NUM_BINS-1)`.
    - Set `m_axis_tvalid`; go to OUT.
  - OUT: hold all outputs until `tvalid & tready`. On the handshake, drop `tvalid`.
    - If `bin_idx == NUM_BINS-1`, go to DONE.
    - Otherwise increment `bin_idx` and go to READ.
  - DONE: `total_count <= cdf`; pulse `sweep_done`; go to IDLE.
- Saturation: CDF addition is unsigned and saturating at all-ones. Saturation sets `cdf_sat`. Later bins still stream, carrying the saturated CDF.
- Host arbitration:
  - The host is granted the port in any cycle where the state is not READ, `host_req` is high, and no host read is in flight.
  - Grant cycle G: `hist_read_addr = host_addr`; set the in-flight flag.
  - Cycle G+1: `host_data <= hist_read_data`; `host_ack <= 1`.
  - Cycle G+2: `host_ack` is high and the in-flight flag clears. The host drops `host_req` in this cycle.
  - The earliest regrant is G+3, which prevents double service.
  - Sweep priority: READ always belongs to the sweep. A host request arriving in READ is granted in the next cycle (maximum wait 1 cycle).
- `hist_read_addr` is combinational from the registered state, `bin_idx` and `host_addr`. When neither the sweep nor the host owns the port, it equals `bin_idx`.

## Timing
- Reset values:
  - `hist_read_addr` is 0.
  - `host_ack` and `host_data` are 0.
  - `m_axis_tvalid`, `tdata`, `tuser` and `tlast` are 0.
  - `sweep_busy` and `sweep_done` are 0.
  - `total_count`, `cdf_sat` and `overrun` are 0.
  - The FSM is IDLE and `done_q` is 0.
  - A reset mid-sweep aborts immediately with no partial `sweep_done`. After reset, a level-high `hist_frame_done` counts as a rising edge, because `done_q` resets to 0.
- Trigger latency: trigger seen in cycle T; READ in T+1; `m_axis_tvalid` high in T+3 for bin 0.
- Throughput: 3 cycles per bin with `tready` held high, so a full sweep takes 3*NUM_BINS cycles (768 for 256 bins). `sweep_done` pulses 1 cycle after the final handshake.
- AXI-Stream rules:
  - `tvalid` never drops without a handshake.
  - `tdata`, `tuser` and `tlast` are stable while `tvalid & ~tready`.
- Host latency: the ack arrives 2 cycles after the grant cycle.
- Simultaneous events:
  - Host request and sweep READ in the same cycle: the sweep wins.
  - Trigger in the same cycle as DONE: it counts as busy; set `overrun`, no new sweep.

## Test plan
- Histogram model with `bin[i]=i` and `tready=1`. Trigger; check:
  - 256 beats, with beat k's `tdata = {k(k+1)/2, k}`;
  - `tuser` only on beat 0 and `tlast` only on beat 255;
  - `total_count = 32640` and one `sweep_done` pulse;
  - trigger-to-first-valid = 3 cycles, and 3 cycles between beats.
- Random `tready` backpressure (~50%): the same data sequence with no drops or duplicates, and outputs stable while stalled.
- `bin[0]=0xFFFF_FFF0`, `bin[1]=0x20`, others 0: beat 1 CDF = `0xFFFF_FFFF`, `cdf_sat=1`, `total_count=0xFFFF_FFFF`.
- Host reads of addresses 7 and 200 in IDLE and during a sweep (with `bin[i]=i`):
  - `host_data` = 7 and 200;
  - ack 2 cycles after the grant;
  - the grant waits at most 1 cycle when colliding with READ;
  - the sweep data is unaffected.
- Second `hist_frame_done` rising edge mid-sweep: `overrun=1`, the sweep completes normally, and no second sweep starts.
- Assert `rst_n` low at bin 100: all outputs return to reset values immediately. A later trigger gives a fresh sweep starting at bin 0 with CDF starting from 0.

Source files
------------

// File: rtl/hist_sweep_ctrl.sv
// hist_sweep_ctrl
// ---------------
// Sweeps all histogram bins after each frame and streams {cdf, bin_count}
// on AXI4-Stream while accumulating a saturating cumulative distribution.
// It also shares the histogram's single read port with a host word-read
// interface. The sweep always owns the port in READ; the host may take it
// in any other cycle.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   hist_frame_done   frame-complete level; rising edge starts a sweep
//   hist_read_addr    histogram read address (data returns one cycle later)
//   hist_read_data    histogram read data
//   host_req/addr     host read request (held until ack) and bin address
//   host_ack/data     one-cycle ack with the read result (data held)
//   m_axis_*          sweep output stream, tdata = {cdf, bin_count}
//   sweep_busy        high whenever the sequencer is not idle
//   sweep_done        one-cycle pulse at the end of a sweep
//   total_count       final CDF of the last completed sweep
//   cdf_sat           sticky CDF-saturation flag for the current/last sweep
//   overrun           sticky: trigger arrived while busy (reset clears)

module hist_sweep_ctrl #(
  parameter int BIN_WIDTH  = 32,
  parameter int NUM_BINS   = 256,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   hist_frame_done,
  output logic [ADDR_WIDTH-1:0]  hist_read_addr,
  input  logic [BIN_WIDTH-1:0]   hist_read_data,
  input  logic                   host_req,
  input  logic [ADDR_WIDTH-1:0]  host_addr,
  output logic                   host_ack,
  output logic [BIN_WIDTH-1:0]   host_data,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic [2*BIN_WIDTH-1:0] m_axis_tdata,
  output logic                   m_axis_tuser,
  output logic                   m_axis_tlast,
  output logic                   sweep_busy,
  output logic                   sweep_done,
  output logic [BIN_WIDTH-1:0]   total_count,
  output logic                   cdf_sat,
  output logic                   overrun
);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    CAPTURE,
    OUT,
    DONE
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_BIN = ADDR_WIDTH'(NUM_BINS - 1);

  state_t                 state_reg, state_next;
  logic                   done_q_reg;
  logic [ADDR_WIDTH-1:0]  bin_idx_reg;
  logic [BIN_WIDTH-1:0]   cdf_reg;
  logic                   cdf_sat_reg;
  logic                   overrun_reg;
  logic [BIN_WIDTH-1:0]   total_count_reg;
  logic                   tvalid_reg;
  logic                   tuser_reg;
  logic                   tlast_reg;
  logic [2*BIN_WIDTH-1:0] tdata_reg;
  // host_pend_reg marks the cycle after a grant (data on the bus);
  // host_ack_reg the cycle after that. Together they form the in-flight flag.
  logic                   host_pend_reg;
  logic                   host_ack_reg;
  logic [BIN_WIDTH-1:0]   host_data_reg;

  logic                   trigger;
  logic                   host_grant;
  logic                   handshake;
  logic                   last_bin;
  logic [BIN_WIDTH:0]     cdf_sum;
  logic                   cdf_ovf;
  logic [BIN_WIDTH-1:0]   cdf_next;

  assign trigger    = hist_frame_done & ~done_q_reg;
  assign host_grant = (state_reg != READ) & host_req & ~host_pend_reg & ~host_ack_reg;
  assign handshake  = tvalid_reg & m_axis_tready;
  assign last_bin   = (bin_idx_reg == LAST_BIN);

  // One extra bit catches the carry; any carry clamps to all-ones.
  assign cdf_sum  = {1'b0, cdf_reg} + {1'b0, hist_read_data};
  assign cdf_ovf  = cdf_sum[BIN_WIDTH];
  assign cdf_next = cdf_ovf ? '1 : cdf_sum[BIN_WIDTH-1:0];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state and combinational outputs
  always_comb begin
    state_next     = state_reg;
    hist_read_addr = bin_idx_reg;
    sweep_busy     = (state_reg != IDLE);
    sweep_done     = 1'b0;
    if (host_grant) begin
      hist_read_addr = host_addr;
    end
    case (state_reg)
      IDLE:    if (trigger) state_next = READ;
      READ: begin
        hist_read_addr = bin_idx_reg;
        state_next     = CAPTURE;
      end
      CAPTURE: state_next = OUT;
      OUT:     if (handshake) state_next = last_bin ? DONE : READ;
      DONE: begin
        sweep_done = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Sweep datapath, stream registers and host read pipeline
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q_reg      <= 1'b0;
      bin_idx_reg     <= '0;
      cdf_reg         <= '0;
      cdf_sat_reg     <= 1'b0;
      overrun_reg     <= 1'b0;
      total_count_reg <= '0;
      tvalid_reg      <= 1'b0;
      tuser_reg       <= 1'b0;
      tlast_reg       <= 1'b0;
      tdata_reg       <= '0;
      host_pend_reg   <= 1'b0;
      host_ack_reg    <= 1'b0;
      host_data_reg   <= '0;
    end else begin
      done_q_reg <= hist_frame_done;

      // DONE still counts as busy, so a trigger there is an overrun too.
      if (trigger && (state_reg != IDLE)) begin
        overrun_reg <= 1'b1;
      end

      case (state_reg)
        IDLE: begin
          if (trigger) begin
            bin_idx_reg <= '0;
            cdf_reg     <= '0;
            cdf_sat_reg <= 1'b0;
          end
        end
        CAPTURE: begin
          cdf_reg    <= cdf_next;
          tdata_reg  <= {cdf_next, hist_read_data};
          tuser_reg  <= (bin_idx_reg == '0);
          tlast_reg  <= last_bin;
          tvalid_reg <= 1'b1;
          if (cdf_ovf) begin
            cdf_sat_reg <= 1'b1;
          end
        end
        OUT: begin
          if (handshake) begin
            tvalid_reg <= 1'b0;
            if (!last_bin) begin
              bin_idx_reg <= bin_idx_reg + ADDR_WIDTH'(1);
            end
          end
        end
        DONE: total_count_reg <= cdf_reg;
        default: ;
      endcase

      host_pend_reg <= host_grant;
      host_ack_reg  <= host_pend_reg;
      if (host_pend_reg) begin
        host_data_reg <= hist_read_data;
      end
    end
  end

  assign host_ack      = host_ack_reg;
  assign host_data     = host_data_reg;
  assign m_axis_tvalid = tvalid_reg;
  assign m_axis_tdata  = tdata_reg;
  assign m_axis_tuser  = tuser_reg;
  assign m_axis_tlast  = tlast_reg;
  assign total_count   = total_count_reg;
  assign cdf_sat       = cdf_sat_reg;
  assign overrun       = overrun_reg;

endmodule

// File: tb/tb_hist_sweep_ctrl.sv
// Testbench for hist_sweep_ctrl: histogram memory model with one-cycle read
// latency, random backpressure and host reads, and a reference model that
// derives each beat from saturated prefix sums of the bin array.

module tb_hist_sweep_ctrl;

  localparam int NB = 256;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hist_frame_done;
  logic [7:0]  hist_read_addr;
  logic [31:0] hist_read_data = '0;
  logic        host_req;
  logic [7:0]  host_addr;
  logic        host_ack;
  logic [31:0] host_data;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b1;
  logic [63:0] m_axis_tdata;
  logic        m_axis_tuser;
  logic        m_axis_tlast;
  logic        sweep_busy;
  logic        sweep_done;
  logic [31:0] total_count;
  logic        cdf_sat;
  logic        overrun;

  hist_sweep_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .hist_frame_done (hist_frame_done),
    .hist_read_addr  (hist_read_addr),
    .hist_read_data  (hist_read_data),
    .host_req        (host_req),
    .host_addr       (host_addr),
    .host_ack        (host_ack),
    .host_data       (host_data),
    .m_axis_tvalid   (m_axis_tvalid),
    .m_axis_tready   (m_axis_tready),
    .m_axis_tdata    (m_axis_tdata),
    .m_axis_tuser    (m_axis_tuser),
    .m_axis_tlast    (m_axis_tlast),
    .sweep_busy      (sweep_busy),
    .sweep_done      (sweep_done),
    .total_count     (total_count),
    .cdf_sat         (cdf_sat),
    .overrun         (overrun)
  );

  always #5 clk = ~clk;

  // Histogram memory model: registered read, one cycle latency.
  logic [31:0] mem [NB];
  always @(posedge clk) hist_read_data <= mem[hist_read_addr];

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [65:0] got, input logic [65:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: expected beats of the next sweep.
  typedef struct {
    int          k;
    logic [63:0] data;
  } beat_t;

  beat_t       exp_q[$];
  logic [31:0] exp_total;
  logic        exp_sat;
  int          exp_done  = 0;
  int          done_cnt  = 0;
  int          trig_cyc  = 0;
  bit          bp_en     = 1'b0;
  bit          timing_chk = 1'b0;

  // cdf_k is the true prefix sum clamped to all-ones (bins are non-negative,
  // so the clamp of the prefix equals the running saturating sum).
  task automatic load_expected();
    longint unsigned sum;
    sum = 0;
    exp_q.delete();
    for (int k = 0; k < NB; k++) begin
      beat_t       b;
      logic [31:0] c;
      sum += 64'(mem[k]);
      c = (sum > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : sum[31:0];
      b.k    = k;
      b.data = {c, mem[k]};
      exp_q.push_back(b);
      exp_total = c;
    end
    exp_sat = (sum > 64'hFFFF_FFFF);
  endtask

  // Downstream ready: random when backpressure is enabled.
  always @(posedge clk) begin
    #1;
    m_axis_tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Stream monitor: checks each handshake against the model, inter-beat
  // timing when ready is held high, and stability while stalled.
  bit          stall_prev = 1'b0;
  logic [65:0] held;
  int          last_hs = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("hold_tvalid", 66'(m_axis_tvalid), 66'(1));
        check("hold_tdata", {m_axis_tdata, m_axis_tuser, m_axis_tlast}, held);
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 66'(1), 66'(0));
        end else begin
          beat_t b;
          b = exp_q.pop_front();
          check("tdata", 66'(m_axis_tdata), 66'(b.data));
          check("tuser", 66'(m_axis_tuser), 66'(b.k == 0));
          check("tlast", 66'(m_axis_tlast), 66'(b.k == NB - 1));
          if (timing_chk) begin
            if (b.k == 0) check("first_valid_lat", 66'(cyc - trig_cyc), 66'(3));
            else          check("beat_gap", 66'(cyc - last_hs), 66'(3));
          end
          last_hs = cyc;
        end
      end
      stall_prev = m_axis_tvalid && !m_axis_tready;
      held       = {m_axis_tdata, m_axis_tuser, m_axis_tlast};
      if (sweep_done) done_cnt++;
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd_addr"}, 66'(hist_read_addr), 66'(0));
    check({tag, "_host_ack"}, 66'(host_ack), 66'(0));
    check({tag, "_host_data"}, 66'(host_data), 66'(0));
    check({tag, "_tvalid"}, 66'(m_axis_tvalid), 66'(0));
    check({tag, "_tdata"}, 66'(m_axis_tdata), 66'(0));
    check({tag, "_tuser"}, 66'(m_axis_tuser), 66'(0));
    check({tag, "_tlast"}, 66'(m_axis_tlast), 66'(0));
    check({tag, "_busy"}, 66'(sweep_busy), 66'(0));
    check({tag, "_done"}, 66'(sweep_done), 66'(0));
    check({tag, "_total"}, 66'(total_count), 66'(0));
    check({tag, "_cdf_sat"}, 66'(cdf_sat), 66'(0));
    check({tag, "_overrun"}, 66'(overrun), 66'(0));
  endtask

  task automatic start_sweep();
    @(posedge clk); #1;
    hist_frame_done = 1'b0;
    @(posedge clk); #1;
    load_expected();
    hist_frame_done = 1'b1;
    trig_cyc = cyc;
  endtask

  task automatic wait_done(input string name);
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!sweep_done && t < 4000);
    check({name, "_timeout"}, 66'(t < 4000), 66'(1));
    exp_done++;
    @(negedge clk);
    check({name, "_done_pulse"}, 66'(sweep_done), 66'(0));
    check({name, "_busy"}, 66'(sweep_busy), 66'(0));
    check({name, "_total"}, 66'(total_count), 66'(exp_total));
    check({name, "_cdf_sat"}, 66'(cdf_sat), 66'(exp_sat));
    check({name, "_beats_left"}, 66'(exp_q.size()), 66'(0));
    $display("sweep %s: total_count=0x%0h cdf_sat=%0b", name, total_count, cdf_sat);
  endtask

  task automatic host_read(input logic [7:0] a, input bit idle);
    int req_cyc, t, lat;
    @(posedge clk); #1;
    host_req  = 1'b1;
    host_addr = a;
    req_cyc   = cyc;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!host_ack && t < 10);
    check("host_timeout", 66'(t < 10), 66'(1));
    lat = cyc - req_cyc;
    if (idle) check("host_lat", 66'(lat), 66'(2));
    else      check("host_lat_range", 66'(lat == 2 || lat == 3), 66'(1));
    check("host_data", 66'(host_data), 66'(mem[a]));
    host_req = 1'b0;
    @(negedge clk);
    check("host_ack_pulse", 66'(host_ack), 66'(0));
    $display("host read addr=%0d data=%0d latency=%0d", a, host_data, lat);
  endtask

  initial begin
    rst_n           = 1'b0;
    hist_frame_done = 1'b0;
    host_req        = 1'b0;
    host_addr       = '0;
    for (int i = 0; i < NB; i++) mem[i] = 32'(i);

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Ramp histogram, ready held high, timing checked.
    timing_chk = 1'b1;
    start_sweep();
    wait_done("ramp");

    // Same data under random backpressure.
    bp_en = 1'b1;
    timing_chk = 1'b0;
    start_sweep();
    wait_done("ramp_bp");

    // Random bin contents under backpressure.
    for (int i = 0; i < NB; i++) mem[i] = 32'($urandom_range(0, 32'h00FF_FFFF));
    start_sweep();
    wait_done("random_bp");

    // Host reads while idle.
    for (int i = 0; i < NB; i++) mem[i] = 32'(i);
    bp_en = 1'b0;
    timing_chk = 1'b1;
    repeat (3) @(posedge clk);
    host_read(8'd7, 1'b1);
    host_read(8'd200, 1'b1);

    // Host reads interleaved with a sweep; sweep timing and data must hold.
    start_sweep();
    host_read(8'd7, 1'b0);
    host_read(8'd200, 1'b0);
    for (int n = 0; n < 6; n++) begin
      repeat ($urandom_range(0, 30)) @(posedge clk);
      host_read(8'($urandom_range(0, NB - 1)), 1'b0);
    end
    wait_done("host_mix");

    // Second trigger mid-sweep: overrun, no extra sweep.
    check("overrun_clear", 66'(overrun), 66'(0));
    start_sweep();
    repeat (60) @(posedge clk);
    #1 hist_frame_done = 1'b0;
    @(posedge clk); #1;
    hist_frame_done = 1'b1;
    @(negedge clk);
    check("overrun_pre", 66'(overrun), 66'(0));
    @(negedge clk);
    check("overrun_set", 66'(overrun), 66'(1));
    wait_done("overrun");
    repeat (30) @(negedge clk);
    check("no_second_sweep_busy", 66'(sweep_busy), 66'(0));
    check("no_second_sweep_valid", 66'(m_axis_tvalid), 66'(0));
    check("overrun_sticky", 66'(overrun), 66'(1));

    // Saturating CDF.
    for (int i = 0; i < NB; i++) mem[i] = '0;
    mem[0] = 32'hFFFF_FFF0;
    mem[1] = 32'h0000_0020;
    start_sweep();
    wait_done("saturate");

    // Reset at bin 100, then a fresh sweep from the level-high trigger.
    for (int i = 0; i < NB; i++) mem[i] = 32'(i);
    start_sweep();
    begin
      int t;
      t = 0;
      while (exp_q.size() > NB - 100 && t < 2000) begin
        @(negedge clk);
        t++;
      end
      check("reach_bin100", 66'(t < 2000), 66'(1));
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    load_expected();
    rst_n    = 1'b1;
    trig_cyc = cyc;
    wait_done("post_reset");

    check("sweep_done_count", 66'(done_cnt), 66'(exp_done));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
